// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with wrap, saturate and one-shot end-of-range handling,
// synchronous clear/load, limit flags and a registered range-event pulse.
module updown_counter_param #(
    parameter int                WIDTH       = 4,
    parameter longint unsigned   MAX_VALUE   = (64'd1 << WIDTH) - 64'd1,
    parameter int                MODE        = 0,
    parameter longint unsigned   RESET_VALUE = 64'd0
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic             DIRECTION,
    input  logic             CLEAR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VALUE,
    output logic [WIDTH-1:0] COUNT_OUT,
    output logic             AT_MAX,
    output logic             AT_ZERO,
    output logic             EVENT,
    output logic             DONE
);

    localparam logic [WIDTH-1:0] MAX_V   = MAX_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] RESET_V = RESET_VALUE[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    localparam int MODE_WRAP     = 0;
    localparam int MODE_SATURATE = 1;
    localparam int MODE_ONE_SHOT = 2;

    logic [WIDTH-1:0] count_q;
    logic             event_q;
    logic             done_q;
    logic             at_limit;
    logic             step_ok;
    logic [WIDTH-1:0] wrap_target;
    logic [WIDTH-1:0] load_clamped;

    // Limit is compared before stepping so non-power-of-two ranges never rely on overflow.
    assign at_limit     = DIRECTION ? (count_q == '0) : (count_q == MAX_V);
    assign wrap_target  = DIRECTION ? MAX_V : '0;
    assign load_clamped = (LOAD_VALUE > MAX_V) ? MAX_V : LOAD_VALUE;
    assign step_ok      = ENABLE && !((MODE == MODE_ONE_SHOT) && done_q);

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            count_q <= RESET_V;
            event_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (CLEAR) begin
            count_q <= RESET_V;
            event_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (LOAD) begin
            count_q <= load_clamped;
            event_q <= 1'b0;
            done_q  <= 1'b0;
        end else if (step_ok) begin
            if (at_limit) begin
                event_q <= 1'b1;
                if (MODE == MODE_WRAP) begin
                    count_q <= wrap_target;
                end else if (MODE == MODE_ONE_SHOT) begin
                    done_q <= 1'b1;
                end
            end else begin
                event_q <= 1'b0;
                count_q <= DIRECTION ? (count_q - ONE) : (count_q + ONE);
            end
        end else begin
            event_q <= 1'b0;
        end
    end

    assign COUNT_OUT = count_q;
    assign AT_MAX    = (count_q == MAX_V);
    assign AT_ZERO   = (count_q == '0);
    assign EVENT     = event_q;
    assign DONE      = (MODE == MODE_ONE_SHOT) ? done_q : 1'b0;

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: four configurations driven side by side and compared
// against an arithmetic reference model, with directed scenarios followed by random traffic.
module tb_updown_counter_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en;
    logic       dir;
    logic       clr;
    logic       ld_en;
    logic [5:0] ld [4];

    logic [3:0] c0, c1, c2;
    logic [4:0] c3;
    logic [3:0] evt, done, amax, azero;
    logic [31:0] obs_cnt [4];

    assign obs_cnt[0] = 32'(c0);
    assign obs_cnt[1] = 32'(c1);
    assign obs_cnt[2] = 32'(c2);
    assign obs_cnt[3] = 32'(c3);

    updown_counter_param #(.WIDTH(4), .MAX_VALUE(9), .MODE(0), .RESET_VALUE(0)) u0 (
        .CLOCK(clk), .RESET(rst), .ENABLE(en), .DIRECTION(dir), .CLEAR(clr), .LOAD(ld_en),
        .LOAD_VALUE(ld[0][3:0]), .COUNT_OUT(c0), .AT_MAX(amax[0]), .AT_ZERO(azero[0]),
        .EVENT(evt[0]), .DONE(done[0]));

    updown_counter_param #(.WIDTH(4), .MAX_VALUE(15), .MODE(1), .RESET_VALUE(0)) u1 (
        .CLOCK(clk), .RESET(rst), .ENABLE(en), .DIRECTION(dir), .CLEAR(clr), .LOAD(ld_en),
        .LOAD_VALUE(ld[1][3:0]), .COUNT_OUT(c1), .AT_MAX(amax[1]), .AT_ZERO(azero[1]),
        .EVENT(evt[1]), .DONE(done[1]));

    updown_counter_param #(.WIDTH(4), .MAX_VALUE(5), .MODE(2), .RESET_VALUE(0)) u2 (
        .CLOCK(clk), .RESET(rst), .ENABLE(en), .DIRECTION(dir), .CLEAR(clr), .LOAD(ld_en),
        .LOAD_VALUE(ld[2][3:0]), .COUNT_OUT(c2), .AT_MAX(amax[2]), .AT_ZERO(azero[2]),
        .EVENT(evt[2]), .DONE(done[2]));

    updown_counter_param #(.WIDTH(5), .MAX_VALUE(20), .MODE(2), .RESET_VALUE(3)) u3 (
        .CLOCK(clk), .RESET(rst), .ENABLE(en), .DIRECTION(dir), .CLEAR(clr), .LOAD(ld_en),
        .LOAD_VALUE(ld[3][4:0]), .COUNT_OUT(c3), .AT_MAX(amax[3]), .AT_ZERO(azero[3]),
        .EVENT(evt[3]), .DONE(done[3]));

    int unsigned p_max  [4] = '{9, 15, 5, 20};
    int unsigned p_mode [4] = '{0, 1, 2, 2};
    int unsigned p_rv   [4] = '{0, 0, 0, 3};
    int unsigned p_mask [4] = '{15, 15, 15, 31};

    int unsigned m_cnt  [4];
    bit          m_evt  [4];
    bit          m_done [4];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i]  = p_rv[i];
            m_evt[i]  = 1'b0;
            m_done[i] = 1'b0;
        end
    endtask

    // Reference behaviour per rising edge, using modulo arithmetic for the wrap case.
    task automatic model_edge();
        int unsigned lv;
        bit          at_lim;
        if (rst) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            if (clr) begin
                m_cnt[i] = p_rv[i]; m_evt[i] = 1'b0; m_done[i] = 1'b0;
            end else if (ld_en) begin
                lv = 32'(ld[i]) & p_mask[i];
                m_cnt[i] = (lv > p_max[i]) ? p_max[i] : lv;
                m_evt[i] = 1'b0; m_done[i] = 1'b0;
            end else if (en && !m_done[i]) begin
                at_lim   = dir ? (m_cnt[i] == 0) : (m_cnt[i] == p_max[i]);
                m_evt[i] = at_lim;
                if (p_mode[i] == 0)
                    m_cnt[i] = dir ? (m_cnt[i] + p_max[i]) % (p_max[i] + 1)
                                   : (m_cnt[i] + 1) % (p_max[i] + 1);
                else if (!at_lim)
                    m_cnt[i] = dir ? m_cnt[i] - 1 : m_cnt[i] + 1;
                else if (p_mode[i] == 2)
                    m_done[i] = 1'b1;
            end else begin
                m_evt[i] = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("cnt[%0d]", i),   obs_cnt[i],   m_cnt[i]);
            chk($sformatf("event[%0d]", i), 32'(evt[i]),  32'(m_evt[i]));
            chk($sformatf("done[%0d]", i),  32'(done[i]), 32'(m_done[i]));
            chk($sformatf("at_max[%0d]", i),  32'(amax[i]),  32'(m_cnt[i] == p_max[i]));
            chk($sformatf("at_zero[%0d]", i), 32'(azero[i]), 32'(m_cnt[i] == 0));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic set_ld(input logic [5:0] v0, input logic [5:0] v1,
                          input logic [5:0] v2, input logic [5:0] v3);
        ld[0] = v0; ld[1] = v1; ld[2] = v2; ld[3] = v3;
    endtask

    initial begin
        int exp_up [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

        rst = 1'b1; en = 1'b0; dir = 1'b0; clr = 1'b0; ld_en = 1'b0;
        set_ld(0, 0, 0, 0);
        model_reset();
        #2;
        check_all();
        chk("reset_cnt3", obs_cnt[3], 3);
        #10 rst = 1'b0;

        // Up-count with wrap on the 0..9 counter.
        en = 1'b1; dir = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("up_cnt_%0d", i), obs_cnt[0], exp_up[i]);
            chk($sformatf("up_evt_%0d", i), 32'(evt[0]), 32'(i == 9));
            chk($sformatf("up_atmax_%0d", i), 32'(amax[0]), 32'(i == 8));
        end

        // Down wrap and direction flip.
        en = 1'b0; ld_en = 1'b1; set_ld(1, 1, 1, 1);
        tick();
        ld_en = 1'b0; en = 1'b1; dir = 1'b1;
        tick(); chk("dn_cnt_a", obs_cnt[0], 0); chk("dn_evt_a", 32'(evt[0]), 0);
        tick(); chk("dn_cnt_b", obs_cnt[0], 9); chk("dn_evt_b", 32'(evt[0]), 1);
        tick(); chk("dn_cnt_c", obs_cnt[0], 8); chk("dn_evt_c", 32'(evt[0]), 0);
        dir = 1'b0;
        tick(); chk("flip_cnt", obs_cnt[0], 9); chk("flip_evt", 32'(evt[0]), 0);

        // Saturate at 15.
        en = 1'b0; ld_en = 1'b1; set_ld(14, 14, 14, 14);
        tick();
        ld_en = 1'b0; en = 1'b1; dir = 1'b0;
        tick(); chk("sat_cnt_a", obs_cnt[1], 15); chk("sat_evt_a", 32'(evt[1]), 0);
        tick(); chk("sat_cnt_b", obs_cnt[1], 15); chk("sat_evt_b", 32'(evt[1]), 1);
        tick(); chk("sat_cnt_c", obs_cnt[1], 15); chk("sat_evt_c", 32'(evt[1]), 1);

        // One-shot on 0..5, then re-arm by LOAD.
        en = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0; en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("os_cnt_%0d", i), obs_cnt[2], (i < 5) ? i + 1 : 5);
            chk($sformatf("os_evt_%0d", i), 32'(evt[2]), 32'(i == 5));
            chk($sformatf("os_done_%0d", i), 32'(done[2]), 32'(i >= 5));
        end
        ld_en = 1'b1; set_ld(2, 2, 2, 2);
        tick(); chk("rearm_cnt", obs_cnt[2], 2); chk("rearm_done", 32'(done[2]), 0);
        ld_en = 1'b0;
        tick(); chk("resume_cnt", obs_cnt[2], 3);

        // Priority and load clamp.
        clr = 1'b1; ld_en = 1'b1; en = 1'b1; set_ld(13, 13, 13, 13);
        tick(); chk("prio_cnt0", obs_cnt[0], 0); chk("prio_cnt3", obs_cnt[3], 3);
        clr = 1'b0;
        tick();
        chk("clamp_cnt0", obs_cnt[0], 9); chk("clamp_cnt1", obs_cnt[1], 13);
        chk("clamp_cnt2", obs_cnt[2], 5); chk("clamp_cnt3", obs_cnt[3], 13);

        // Asynchronous reset between edges while events are in flight.
        en = 1'b0; ld_en = 1'b1; set_ld(8, 0, 0, 0);
        tick();
        ld_en = 1'b0; en = 1'b1; dir = 1'b1;
        tick(); chk("pre_rst_cnt0", obs_cnt[0], 7); chk("pre_rst_evt1", 32'(evt[1]), 1);
        #3 rst = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("async_cnt0", obs_cnt[0], 0); chk("async_evt1", 32'(evt[1]), 0);
        chk("async_cnt3", obs_cnt[3], 3); chk("async_done3", 32'(done[3]), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_hold_%0d", i), obs_cnt[3], 3);
        end
        #2 rst = 1'b0;
        tick();

        // Random traffic, including occasional asynchronous reset pulses.
        for (int n = 0; n < 400; n++) begin
            rst   = 1'b0;
            clr   = ($urandom_range(0, 15) == 0);
            ld_en = ($urandom_range(0, 7) == 0);
            en    = ($urandom_range(0, 3) != 0);
            dir   = ($urandom_range(0, 2) == 0) ? ~dir : dir;
            for (int i = 0; i < 4; i++) ld[i] = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 40) == 0) begin
                #2 rst = 1'b1;
                model_reset();
                #1;
                check_all();
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
